// File: rtl/avalon_pio_edge_capture.sv
// avalon_pio_edge_capture: Avalon-MM input PIO with synchroniser, W1C edge capture and masked level IRQ
module avalon_pio_edge_capture #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] d_sync, d_prev_q, edge_q, edge_d, mask_q, mask_d, rise, fall, evt, clr;
  logic [31:0] readdata_d;
  logic wr;
  assign d_sync = sync_q[SYNC_STAGES-1];
  assign wr     = chipselect && !write_n;
  always_comb begin
    rise       = d_sync & ~d_prev_q;
    fall       = ~d_sync & d_prev_q;
    evt        = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
    clr        = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // OR-ing the event last lets a same-cycle set win over a W1C of that bit
    edge_d     = (edge_q & ~clr) | evt;
    mask_d     = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    readdata_d = address == 2'd0 ? 32'(d_sync) :
                 address == 2'd2 ? 32'(mask_q) :
                 address == 2'd3 ? 32'(edge_q) : 32'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      d_prev_q <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      d_prev_q <= d_sync;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      readdata <= readdata_d;
      irq      <= |(edge_q & mask_q);
    end
  end
endmodule

// File: tb/tb_avalon_pio_edge_capture.sv
// tb_avalon_pio_edge_capture: rising-edge and any-edge instances checked against a sample-history model
module tb_avalon_pio_edge_capture;
  localparam int W = 8, S = 2;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = 0;
  logic [31:0] rd0, rd2;
  logic irq0, irq2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  avalon_pio_edge_capture #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  avalon_pio_edge_capture #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  // Model: the visible level is the in_port sample taken S edges ago; an edge is a change
  // between consecutive visible samples. Capture sets sticky bits, W1C clears them.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_mask, m_e0, m_e2, ds, dp, clr;
  logic [31:0] m_rd0, m_rd2;
  logic m_irq0, m_irq2, m_wr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist = {};
      for (int i = 0; i <= S; i++) hist.push_front('0);
      m_mask = 0; m_e0 = 0; m_e2 = 0; m_rd0 = 0; m_rd2 = 0; m_irq0 = 0; m_irq2 = 0;
    end else begin
      ds = hist[S-1];
      dp = hist[S];
      m_wr = chipselect && !write_n;
      clr = (m_wr && address == 3) ? writedata[W-1:0] : '0;
      m_irq0 = (m_e0 & m_mask) != 0;
      m_irq2 = (m_e2 & m_mask) != 0;
      m_rd0 = address == 0 ? {24'd0, ds} : address == 2 ? {24'd0, m_mask} : address == 3 ? {24'd0, m_e0} : 0;
      m_rd2 = address == 0 ? {24'd0, ds} : address == 2 ? {24'd0, m_mask} : address == 3 ? {24'd0, m_e2} : 0;
      for (int i = 0; i < W; i++) begin
        if (clr[i]) begin m_e0[i] = 0; m_e2[i] = 0; end
        if (ds[i] && !dp[i]) m_e0[i] = 1;
        if (ds[i] != dp[i]) m_e2[i] = 1;
      end
      if (m_wr && address == 2) m_mask = writedata[W-1:0];
      hist.push_front(in_port);
      void'(hist.pop_back());
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1; writedata = $urandom;
  endtask

  task automatic test_reset;
    reset = 1; in_port = 8'hFF; address = 0;
    cyc(3);
    checks++; if (rd0 !== 0 || irq0 !== 0 || rd2 !== 0 || irq2 !== 0) begin errors++;
      $display("FAIL reset_hold: rd0=%h irq0=%b rd2=%h irq2=%b expected 0/0", rd0, irq0, rd2, irq2); end
    reset = 0;
    cyc(3);
    checks++; if (rd0 !== 32'hFF || rd2 !== 32'hFF) begin errors++;
      $display("FAIL reset_data: rd0=%h rd2=%h expected 000000ff", rd0, rd2); end
    checks++; if (rd0 !== m_rd0 || irq0 !== m_irq0) begin errors++;
      $display("FAIL reset_model: rd0=%h irq0=%b expected %h %b", rd0, irq0, m_rd0, m_irq0); end
  endtask

  task automatic test_rising;
    in_port = 0; cyc(4);
    wr(3, 32'hFF); wr(2, 32'h01);
    address = 3;
    in_port[0] = 1;
    cyc(3);
    checks++; if (irq0 !== 0) begin errors++; $display("FAIL rise_irq_early: irq0=%b expected 0", irq0); end
    cyc(1);
    checks++; if (irq0 !== 1 || rd0 !== 32'h1) begin errors++;
      $display("FAIL rise_capture: irq0=%b rd0=%h expected 1 00000001", irq0, rd0); end
    in_port[0] = 0; cyc(4);
    checks++; if (rd0 !== 32'h1 || rd2 !== m_rd2) begin errors++;
      $display("FAIL rise_no_fall: rd0=%h rd2=%h expected 00000001 %h", rd0, rd2, m_rd2); end
  endtask

  task automatic test_w1c;
    in_port = 8'h04; cyc(4);
    address = 3; cyc(1);
    checks++; if (rd0 !== 32'h5) begin errors++; $display("FAIL w1c_pending: rd0=%h expected 00000005", rd0); end
    wr(3, 32'h4); address = 3; cyc(2);
    checks++; if (rd0 !== 32'h1 || irq0 !== 1) begin errors++;
      $display("FAIL w1c_partial: rd0=%h irq0=%b expected 00000001 1", rd0, irq0); end
    wr(3, 32'h1);
    checks++; if (irq0 !== 1) begin errors++; $display("FAIL w1c_irq_hold: irq0=%b expected 1", irq0); end
    cyc(1);
    checks++; if (irq0 !== 0 || irq2 !== m_irq2) begin errors++;
      $display("FAIL w1c_irq_drop: irq0=%b irq2=%b expected 0 %b", irq0, irq2, m_irq2); end
  endtask

  task automatic test_simul;
    in_port = 0; cyc(4);
    wr(3, 32'hFF);
    in_port = 8'h04;
    cyc(2);
    wr(3, 32'h4);
    address = 3; cyc(1);
    checks++; if (rd0 !== 32'h4 || rd2 !== 32'h4) begin errors++;
      $display("FAIL simul_set_wins: rd0=%h rd2=%h expected 00000004", rd0, rd2); end
  endtask

  task automatic test_mask;
    wr(3, 32'hFF); wr(2, 0);
    in_port = 8'h0C; cyc(4);
    checks++; if (irq0 !== 0) begin errors++; $display("FAIL mask_gate: irq0=%b expected 0", irq0); end
    wr(2, 32'h08);
    checks++; if (irq0 !== 0) begin errors++; $display("FAIL mask_on_early: irq0=%b expected 0", irq0); end
    cyc(1);
    checks++; if (irq0 !== 1) begin errors++; $display("FAIL mask_on: irq0=%b expected 1", irq0); end
    wr(2, 0);
    cyc(1);
    checks++; if (irq0 !== 0 || irq2 !== 0) begin errors++;
      $display("FAIL mask_off: irq0=%b irq2=%b expected 0", irq0, irq2); end
  endtask

  task automatic test_any_edge_reset;
    in_port = 8'h80; cyc(4);
    wr(3, 32'hFF); wr(2, 32'h80); cyc(2);
    checks++; if (irq2 !== 0) begin errors++; $display("FAIL any_idle: irq2=%b expected 0", irq2); end
    in_port = 0; cyc(1); in_port = 8'h80; cyc(5);
    address = 3; cyc(1);
    checks++; if (irq2 !== 1 || rd2 !== 32'h80 || irq0 !== 1) begin errors++;
      $display("FAIL any_pulse: irq2=%b rd2=%h irq0=%b expected 1 00000080 1", irq2, rd2, irq0); end
    #1 reset = 1; in_port = 0;
    #1;
    checks++; if (irq2 !== 0 || irq0 !== 0 || rd2 !== 0) begin errors++;
      $display("FAIL async_reset: irq2=%b irq0=%b rd2=%h expected 0", irq2, irq0, rd2); end
    cyc(2); reset = 0;
    address = 3; cyc(2);
    checks++; if (rd2 !== 0 || irq2 !== 0) begin errors++;
      $display("FAIL reset_edge: rd2=%h irq2=%b expected 0", rd2, irq2); end
    address = 2; cyc(1);
    checks++; if (rd2 !== 0 || rd0 !== 0) begin errors++;
      $display("FAIL reset_mask: rd2=%h rd0=%h expected 0", rd2, rd0); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      in_port = $urandom_range(3) == 0 ? W'($urandom) : in_port;
      address = 2'($urandom);
      chipselect = $urandom_range(3) == 0;
      write_n = $urandom_range(1);
      writedata = $urandom;
      cyc(1);
      checks++; if (rd0 !== m_rd0 || irq0 !== m_irq0 || rd2 !== m_rd2 || irq2 !== m_irq2) begin errors++;
        $display("FAIL random[%0d]: rd0=%h irq0=%b rd2=%h irq2=%b expected %h %b %h %b",
                 n, rd0, irq0, rd2, irq2, m_rd0, m_irq0, m_rd2, m_irq2); end
    end
    chipselect = 0; write_n = 1;
  endtask

  initial begin
    cyc(1);
    test_reset;
    test_rising;
    test_w1c;
    test_simul;
    test_mask;
    test_any_edge_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
